// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry,
// derived address-field widths, the line storage type and the FSM states.
package cache_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 4;

    localparam int OFF       = $clog2(LINE_WORDS);
    localparam int IDX       = $clog2(NUM_LINES);
    localparam int TAG       = WORD_SIZE - IDX - OFF;
    localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;

    // One cache line viewed as an array of words, word 0 in the low bits.
    typedef logic [LINE_WORDS-1:0][WORD_SIZE-1:0] line_t;

    // CPU address split into tag / index / offset fields.
    typedef struct packed {
        logic [TAG-1:0] tag;
        logic [IDX-1:0] index;
        logic [OFF-1:0] offset;
    } addr_fields_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache. One fill write port,
// one combinational lookup port and a flush that invalidates every line.
module icache_line_array
    import cache_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 flush,
    input  logic                 fill_en,
    input  logic [IDX-1:0]       fill_index,
    input  logic [TAG-1:0]       fill_tag,
    input  logic [LINE_BITS-1:0] fill_data,
    input  logic                 fill_valid,
    input  logic [IDX-1:0]       rd_index,
    input  logic [TAG-1:0]       rd_tag,
    input  logic [OFF-1:0]       rd_offset,
    output logic                 rd_hit,
    output logic [WORD_SIZE-1:0] rd_word
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG-1:0]       tag_arr  [NUM_LINES];
    line_t                data_arr [NUM_LINES];

    // Valid bits: only state cleared by reset; flush beats a same-cycle fill.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= fill_valid;
        end
    end

    // Tag and data arrays are plain storage written by a fill, never reset.
    always_ff @(posedge Clk) begin
        if (fill_en) begin
            tag_arr[fill_index]  <= fill_tag;
            data_arr[fill_index] <= line_t'(fill_data);
        end
    end

    // Lookup: compare the stored tag and pick the addressed word.
    always_comb begin
        rd_hit  = valid_q[rd_index] && (tag_arr[rd_index] == rd_tag);
        rd_word = data_arr[rd_index][rd_offset];
    end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache between the CPU fetch port and
// instruction memory. Hits answer in the same cycle; misses stall the CPU
// through i_ready while a whole line is fetched. Keeps hit/miss counters.
module icache_direct_mapped
    import cache_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 readM1,
    input  logic [WORD_SIZE-1:0] address1,
    output logic [WORD_SIZE-1:0] data1,
    output logic                 i_ready,
    input  logic                 flush,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [LINE_BITS-1:0] mem_data,
    input  logic                 mem_ack,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    state_t               state;
    addr_fields_t         req;
    logic                 hit;
    logic [WORD_SIZE-1:0] hit_word;
    logic                 flush_pending;
    logic                 fill_en;
    logic                 fill_valid;
    logic [WORD_SIZE-1:0] hit_cnt_r;
    logic [WORD_SIZE-1:0] miss_cnt_r;

    assign req = addr_fields_t'(address1);

    // A flush seen at any point of the fetch (including the ack cycle)
    // installs the returning line as invalid so the retry misses again.
    assign fill_en    = (state == FETCH) && mem_ack;
    assign fill_valid = !(flush_pending || flush);

    icache_line_array u_lines (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .flush      (flush),
        .fill_en    (fill_en),
        .fill_index (mem_address[OFF +: IDX]),
        .fill_tag   (mem_address[WORD_SIZE-1 -: TAG]),
        .fill_data  (mem_data),
        .fill_valid (fill_valid),
        .rd_index   (req.index),
        .rd_tag     (req.tag),
        .rd_offset  (req.offset),
        .rd_hit     (hit),
        .rd_word    (hit_word)
    );

    assign data1      = hit ? hit_word : '0;
    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;

    // Ready whenever nothing is stalled: idle with no request, or a hit.
    always_comb begin
        i_ready = 1'b1;
        if (state == FETCH) begin
            i_ready = 1'b0;
        end else if (readM1 && !hit) begin
            i_ready = 1'b0;
        end
    end

    // Miss FSM: latch the line address, hold mem_read until the ack edge.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_address   <= '0;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    if (readM1 && !hit) begin
                        state       <= FETCH;
                        mem_read    <= 1'b1;
                        mem_address <= {address1[WORD_SIZE-1:OFF], {OFF{1'b0}}};
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state         <= IDLE;
                        mem_read      <= 1'b0;
                        flush_pending <= 1'b0;
                    end else if (flush) begin
                        flush_pending <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Performance counters: one event per request cycle seen in IDLE; they wrap.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else if ((state == IDLE) && readM1) begin
            if (hit) begin
                hit_cnt_r <= hit_cnt_r + 1'b1;
            end else begin
                miss_cnt_r <= miss_cnt_r + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed scenarios plus a
// randomized run against a behavioural cache model kept in plain arrays.
module tb_icache_direct_mapped;

    logic        Clk;
    logic        Reset_N;
    logic        readM1;
    logic [15:0] address1;
    logic [15:0] data1;
    logic        i_ready;
    logic        flush;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int tests_run;
    int tests_failed;

    // Behavioural model: per-line valid/tag/words and the two counters.
    bit          m_valid [4];
    logic [11:0] m_tag   [4];
    logic [15:0] m_data  [4][4];
    logic [15:0] m_hit;
    logic [15:0] m_miss;

    // Memory contents: pinned lines plus a computed pattern elsewhere.
    logic [63:0] mem_over [logic [15:0]];

    icache_direct_mapped dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .readM1      (readM1),
        .address1    (address1),
        .data1       (data1),
        .i_ready     (i_ready),
        .flush       (flush),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] mem_line(input logic [15:0] la);
        logic [63:0] l;
        if (mem_over.exists(la)) return mem_over[la];
        for (int w = 0; w < 4; w++) l[w*16 +: 16] = (la + 16'(w)) ^ 16'hC35A;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        m_hit  = '0;
        m_miss = '0;
    endtask

    // One CPU fetch from request to service. Starts just after a rising edge.
    // flush_req flushes in the first request cycle; flush_cyc (1..lat) flushes
    // during that FETCH cycle of the first miss; drop_req releases readM1 while
    // fetching, so the access ends once the fill lands.
    task automatic do_fetch(input logic [15:0] addr, input int lat, input bit flush_req,
                            input int flush_cyc, input bit drop_req);
        logic [11:0] tg;
        int          ix;
        int          of;
        logic [15:0] la;
        logic [63:0] line;
        logic        exp_hit;
        logic [15:0] exp_data;
        bit          served;
        bit          first;
        bit          fill_kill;
        tg = addr[15:4];
        ix = int'(addr[3:2]);
        of = int'(addr[1:0]);
        la = {addr[15:2], 2'b00};
        served = 0;
        first  = 1;
        while (!served) begin
            readM1   = 1'b1;
            address1 = addr;
            flush    = first && flush_req;
            @(negedge Clk);
            exp_hit  = m_valid[ix] && (m_tag[ix] == tg);
            exp_data = exp_hit ? m_data[ix][of] : 16'h0000;
            tests_run++;
            if (i_ready !== exp_hit) begin
                tests_failed++;
                $display("[TB] FAIL req_ready addr=%h: got %b expected %b", addr, i_ready, exp_hit);
            end
            tests_run++;
            if (data1 !== exp_data) begin
                tests_failed++;
                $display("[TB] FAIL req_data addr=%h: got %h expected %h", addr, data1, exp_data);
            end
            tests_run++;
            if (mem_read !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle_mem_read addr=%h: got %b expected 0", addr, mem_read);
            end
            @(posedge Clk);
            if (exp_hit) begin
                m_hit++;
                served = 1;
            end else begin
                m_miss++;
            end
            if (flush) for (int i = 0; i < 4; i++) m_valid[i] = 0;
            #1;
            flush = 1'b0;
            if (!exp_hit) begin
                fill_kill = 0;
                line = mem_line(la);
                for (int c = 1; c <= lat; c++) begin
                    if (drop_req) readM1 = 1'b0;
                    if (first && c == flush_cyc) flush = 1'b1;
                    if (c == lat) begin
                        mem_ack  = 1'b1;
                        mem_data = line;
                    end
                    @(negedge Clk);
                    tests_run++;
                    if (mem_read !== 1'b1 || mem_address !== la || i_ready !== 1'b0) begin
                        tests_failed++;
                        $display("[TB] FAIL fetch_cycle%0d addr=%h: got rd=%b ma=%h rdy=%b expected rd=1 ma=%h rdy=0",
                                 c, addr, mem_read, mem_address, i_ready, la);
                    end
                    @(posedge Clk);
                    if (flush) begin
                        fill_kill = 1;
                        for (int i = 0; i < 4; i++) m_valid[i] = 0;
                    end
                    #1;
                    flush    = 1'b0;
                    mem_ack  = 1'b0;
                    mem_data = {$urandom, $urandom};
                end
                m_tag[ix] = tg;
                for (int w = 0; w < 4; w++) m_data[ix][w] = line[w*16 +: 16];
                m_valid[ix] = !fill_kill;
                if (drop_req) served = 1;
            end
            first = 0;
        end
        readM1 = 1'b0;
        tests_run++;
        if (hit_count !== m_hit || miss_count !== m_miss) begin
            tests_failed++;
            $display("[TB] FAIL counters addr=%h: got hit=%h miss=%h expected hit=%h miss=%h",
                     addr, hit_count, miss_count, m_hit, m_miss);
        end
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        readM1  = 1'b0;
        #12;
        tests_run++;
        if (mem_read !== 1'b0 || mem_address !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem: got rd=%b ma=%h expected rd=0 ma=0000", mem_read, mem_address);
        end
        tests_run++;
        if (hit_count !== 16'h0000 || miss_count !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_counts: got %h/%h expected 0000/0000", hit_count, miss_count);
        end
        tests_run++;
        if (i_ready !== 1'b1 || data1 !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got rdy=%b d=%h expected rdy=1 d=0000", i_ready, data1);
        end
        readM1   = 1'b1;
        address1 = 16'h0010;
        #1;
        tests_run++;
        if (i_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_ready: got %b expected 0", i_ready);
        end
        readM1 = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset_N = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_miss_fill();
        mem_over[16'h0010] = 64'h4444_3333_2222_1111;
        do_fetch(16'h0010, 3, 0, 0, 0);
        tests_run++;
        if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL first_miss_counts: got %0d/%0d expected 1/1", hit_count, miss_count);
        end
    endtask

    task automatic test_hit();
        readM1   = 1'b1;
        address1 = 16'h0013;
        @(negedge Clk);
        tests_run++;
        if (i_ready !== 1'b1 || data1 !== 16'h4444 || mem_read !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_hit: got rdy=%b d=%h rd=%b expected rdy=1 d=4444 rd=0",
                     i_ready, data1, mem_read);
        end
        @(posedge Clk);
        m_hit++;
        #1;
        readM1 = 1'b0;
        tests_run++;
        if (hit_count !== 16'd2) begin
            tests_failed++;
            $display("[TB] FAIL hit_count_after_hit: got %0d expected 2", hit_count);
        end
    endtask

    task automatic test_conflict();
        do_fetch(16'h0050, 2, 0, 0, 0);
        do_fetch(16'h0010, 1, 0, 0, 0);
        tests_run++;
        if (miss_count !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL conflict_misses: got %0d expected 3", miss_count);
        end
    endtask

    task automatic test_flush();
        logic [15:0] misses_before;
        do_fetch(16'h0020, 3, 0, 2, 0);
        // flush alongside a hit: the hit is still served, then all lines go
        do_fetch(16'h0021, 1, 1, 0, 0);
        misses_before = miss_count;
        do_fetch(16'h0022, 2, 0, 0, 0);
        tests_run++;
        if (miss_count !== misses_before + 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL miss_after_flush: got %0d expected %0d", miss_count, misses_before + 16'd1);
        end
        readM1 = 1'b0;
        flush  = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        #1;
        flush = 1'b0;
        do_fetch(16'h0010, 2, 0, 0, 0);
        // fetch with readM1 dropped: fill still lands, next access hits
        do_fetch(16'h0034, 2, 0, 0, 1);
        do_fetch(16'h0035, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_fetch();
        readM1   = 1'b1;
        address1 = 16'h0140;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        Reset_N = 1'b0;
        #1;
        tests_run++;
        if (mem_read !== 1'b0 || hit_count !== 16'h0000 || miss_count !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_abort: got rd=%b hit=%h miss=%h expected rd=0 hit=0000 miss=0000",
                     mem_read, hit_count, miss_count);
        end
        readM1 = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset_N = 1'b1;
        @(posedge Clk);
        #1;
        mem_ack  = 1'b1;
        mem_data = {$urandom, $urandom};
        @(posedge Clk);
        #1;
        mem_ack = 1'b0;
        @(negedge Clk);
        tests_run++;
        if (mem_read !== 1'b0 || i_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stale_ack: got rd=%b rdy=%b expected rd=0 rdy=1", mem_read, i_ready);
        end
        @(posedge Clk);
        #1;
        do_fetch(16'h0140, 2, 0, 0, 0);
        tests_run++;
        if (miss_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL miss_after_reset: got %0d expected 1", miss_count);
        end
    endtask

    task automatic test_counter_wrap();
        do_fetch(16'h0010, 2, 0, 0, 0);
        force dut.hit_cnt_r = 16'hFFFF;
        #1;
        release dut.hit_cnt_r;
        m_hit = 16'hFFFF;
        tests_run++;
        if (hit_count !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL preload_count: got %h expected ffff", hit_count);
        end
        do_fetch(16'h0011, 1, 0, 0, 0);
        tests_run++;
        if (hit_count !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL hit_count_wrap: got %h expected 0000", hit_count);
        end
    endtask

    task automatic test_random();
        logic [15:0] addr;
        int          lat;
        bit          fl;
        int          fc;
        bit          dr;
        for (int n = 0; n < 60; n++) begin
            addr = 16'($urandom_range(0, 63));
            lat  = int'($urandom_range(1, 4));
            fl   = ($urandom_range(0, 7) == 0);
            fc   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            dr   = ($urandom_range(0, 9) == 0);
            do_fetch(addr, lat, fl, fc, dr);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk);
                #1;
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Clk      = 1'b0;
        Reset_N  = 1'b0;
        readM1   = 1'b0;
        address1 = 16'h0000;
        flush    = 1'b0;
        mem_data = '0;
        mem_ack  = 1'b0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_flush();
        test_reset_mid_fetch();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
